video_line_fetch: RTL and testbench

Scanline prefetcher and pixel formatter between the VGA timing generator and the panel/DAC output. It consumes the timing generator's sync, data-enable and position outputs and fetches each visible line of an RGB565 framebuffer from memory into a ping-pong line buffer one line ahead of display. It emits RGB888 pixels aligned with delayed copies of the sync and data-enable signals.

---
 rtl/video_pkg.sv | 23 ++
 rtl/video_line_ram.sv | 19 +
 rtl/video_line_fetch.sv | 132 +++++++++++++
 tb/tb_video_line_fetch.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// video_pkg: pixel formats, colour expansion and fetch-FSM states shared by the line fetcher.
package video_pkg;

    typedef struct packed {
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
    } rgb565_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    typedef enum logic {IDLE, FETCH} fetch_state_t;

    // Replicate the top bits into the low bits so full-scale 565 maps to full-scale 888.
    function automatic rgb888_t expand565(input rgb565_t p);
        return {p.r5, p.r5[4:2], p.g6, p.g6[5:4], p.b5, p.b5[4:2]};
    endfunction

endpackage

// File: rtl/video_line_ram.sv
// video_line_ram: ping-pong line buffer; the address MSB selects the bank.
// Registered read port returns the old word when read and write collide.
module video_line_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/video_line_fetch.sv
// video_line_fetch: prefetches RGB565 scanlines one line ahead into a ping-pong buffer
// and emits RGB888 pixels aligned with 2-cycle-delayed sync and data-enable.
module video_line_fetch
    import video_pkg::*;
#(
    parameter int HLINE = 640,
    parameter int VLINE = 480,
    parameter bit VSPOL = 1'b0
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic        i_data_enable,
    input  logic [10:0] i_pos_x,
    input  logic [10:0] i_pos_y,
    input  logic [31:0] i_fb_base,
    output logic        o_bus_request,
    output logic [31:0] o_bus_address,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_data_enable,
    output logic [7:0]  o_red,
    output logic [7:0]  o_green,
    output logic [7:0]  o_blue,
    output logic        o_underrun
);
    localparam int WW = $clog2(HLINE / 2);
    localparam int LAST = HLINE / 2 - 1;

    fetch_state_t  state;
    logic [WW-1:0] w;
    logic          bank, armed, pend, vs_q;
    logic [31:0]   line_addr, pend_base, fs_base;
    logic [11:0]   y1;
    logic          frame_start, trigger, done;
    logic [31:0]   rdata;
    logic          x0_q, hs1, vs1, de1;
    rgb565_t       pix;
    rgb888_t       px;

    assign frame_start = (i_vsync == VSPOL) && !vs_q;
    assign y1          = {1'b0, i_pos_y} + 12'd1;
    // Triggers are ignored until a frame start has established a valid line address.
    assign trigger     = armed && i_data_enable && i_pos_x == '0 && y1 < 12'(VLINE);
    assign done        = state == FETCH && i_bus_ready;
    assign fs_base     = frame_start ? i_fb_base : pend_base;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state         <= IDLE;
            w             <= '0;
            bank          <= 1'b0;
            armed         <= 1'b0;
            pend          <= 1'b0;
            vs_q          <= 1'b1;
            line_addr     <= '0;
            pend_base     <= '0;
            o_bus_request <= 1'b0;
            o_bus_address <= '0;
            o_underrun    <= 1'b0;
        end else begin
            vs_q <= i_vsync == VSPOL;
            if (frame_start) begin
                armed     <= 1'b1;
                pend_base <= i_fb_base;
            end
            if (state == FETCH && (trigger || frame_start)) o_underrun <= 1'b1;
            if (state == IDLE) begin
                if (frame_start || trigger) begin
                    state         <= FETCH;
                    w             <= '0;
                    bank          <= frame_start ? 1'b0 : y1[0];
                    o_bus_request <= 1'b1;
                    o_bus_address <= frame_start ? i_fb_base : line_addr;
                    if (frame_start) line_addr <= i_fb_base;
                end
            end else if (i_bus_ready) begin
                w <= w + 1'b1;
                // A frame start seen mid-fetch abandons the line once this handshake finishes.
                if (pend || frame_start) begin
                    pend          <= 1'b0;
                    w             <= '0;
                    bank          <= 1'b0;
                    line_addr     <= fs_base;
                    o_bus_address <= fs_base;
                end else if (w == WW'(LAST)) begin
                    state         <= IDLE;
                    o_bus_request <= 1'b0;
                    line_addr     <= line_addr + 32'(2 * HLINE);
                end else begin
                    o_bus_address <= o_bus_address + 32'd4;
                end
            end else if (frame_start) begin
                pend <= 1'b1;
            end
        end
    end

    video_line_ram #(.AW(WW + 1)) u_ram (
        .clk  (i_clock),
        .we   (done),
        .waddr({bank, w}),
        .wdata(i_bus_rdata),
        .raddr({i_pos_y[0], i_pos_x[WW:1]}),
        .rdata(rdata)
    );

    assign pix = x0_q ? rdata[31:16] : rdata[15:0];
    assign px  = expand565(pix);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            {x0_q, hs1, vs1, de1}             <= '0;
            {o_hsync, o_vsync, o_data_enable} <= '0;
            {o_red, o_green, o_blue}          <= '0;
        end else begin
            x0_q          <= i_pos_x[0];
            hs1           <= i_hsync;
            vs1           <= i_vsync;
            de1           <= i_data_enable;
            o_hsync       <= hs1;
            o_vsync       <= vs1;
            o_data_enable <= de1;
            o_red         <= de1 ? px.r : 8'd0;
            o_green       <= de1 ? px.g : 8'd0;
            o_blue        <= de1 ? px.b : 8'd0;
        end
    end
endmodule

// File: tb/tb_video_line_fetch.sv
// tb_video_line_fetch: table vectors, directed bus sequences and a randomized sync/pixel
// reference model for video_line_fetch at HLINE=8, VLINE=4, negative vsync.
module tb_video_line_fetch;
    localparam int HLINE = 8;
    localparam int VLINE = 4;

    logic clk = 1'b0, rst = 1'b1;
    logic hs = 1'b1, vs = 1'b1, de = 1'b0, ready = 1'b0;
    logic [10:0] px = '0, py = '0;
    logic [31:0] base = 32'h1000;
    logic [31:0] addr, rdata;
    logic req, ohs, ovs, ode, und;
    logic [7:0] r, g, b;
    int checks = 0, errors = 0;
    logic chk_pix = 1'b0;
    logic [31:0] tbl_words [4] = '{32'hF800_001F, 32'h07E0_FFFF, 32'h0841_8410, 32'h1234_ABCD};
    logic [31:0] log_q [$];

    typedef struct { int x; logic [23:0] rgb; } vec_t;
    vec_t tbl [8];

    typedef struct packed { logic hs, vs, de, pv; logic [23:0] rgb; } hist_t;
    hist_t h1 = '0, h2 = '0;

    always #5 clk = ~clk;

    video_line_fetch #(.HLINE(HLINE), .VLINE(VLINE), .VSPOL(1'b0)) dut (
        .i_clock(clk), .i_reset(rst), .i_hsync(hs), .i_vsync(vs), .i_data_enable(de),
        .i_pos_x(px), .i_pos_y(py), .i_fb_base(base),
        .o_bus_request(req), .o_bus_address(addr), .i_bus_ready(ready), .i_bus_rdata(rdata),
        .o_hsync(ohs), .o_vsync(ovs), .o_data_enable(ode),
        .o_red(r), .o_green(g), .o_blue(b), .o_underrun(und)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a >= 32'h1000 && a < 32'h1010) return tbl_words[a[3:2]];
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [23:0] exp565(input logic [15:0] p);
        int r5, g6, b5;
        r5 = int'(p[15:11]);
        g6 = int'(p[10:5]);
        b5 = int'(p[4:0]);
        return {8'((r5 << 3) | (r5 >> 2)), 8'((g6 << 2) | (g6 >> 4)), 8'((b5 << 3) | (b5 >> 2))};
    endfunction

    assign rdata = mem_word(addr);

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) if (!rst && req && ready) log_q.push_back(addr);

    // Reference: outputs are the inputs two cycles back; pixels come from the framebuffer at 0x1000.
    always @(negedge clk) begin
        hist_t cur;
        logic [31:0] wd;
        if (rst) begin
            chk("rst_outputs", {addr, ohs, ovs, ode, r, g, b, req, und}, 64'd0);
            h1 = '0;
            h2 = '0;
        end else begin
            chk("sync_delay", {ohs, ovs, ode}, {h2.hs, h2.vs, h2.de});
            if (!h2.de) chk("rgb_blank", {r, g, b}, 64'd0);
            else if (h2.pv) chk("pixel", {r, g, b}, h2.rgb);
            wd = mem_word(32'h1000 + 32'(py) * 32'(2 * HLINE) + 32'(px >> 1) * 32'd4);
            cur = '{hs: hs, vs: vs, de: de, pv: de && chk_pix, rgb: exp565(px[0] ? wd[31:16] : wd[15:0])};
            h2 = h1;
            h1 = cur;
        end
    end

    initial begin
        tbl[0] = '{0, 24'h0000FF};
        tbl[1] = '{1, 24'hFF0000};
        tbl[2] = '{2, 24'hFFFFFF};
        tbl[3] = '{3, 24'h00FF00};
        tbl[4] = '{4, 24'h848284};
        tbl[5] = '{5, 24'h080808};
        tbl[6] = '{6, 24'hAD796B};
        tbl[7] = '{7, 24'h1045A5};

        repeat (3) tick;
        chk("rst_req", req, 0);
        chk("rst_addr", addr, 0);
        chk("rst_und", und, 0);
        chk("rst_rgb", {ode, r, g, b}, 0);
        rst = 1'b0;
        tick;
        tick;
        de = 1'b1; px = 0; py = 0; tick; de = 1'b0; tick;
        chk("pre_vsync_req", req, 0);

        ready = 1'b1; log_q.delete();
        vs = 1'b0; repeat (3) tick; vs = 1'b1; repeat (5) tick;
        chk("f0_count", log_q.size(), 4);
        for (int i = 0; i < 4; i++) chk("f0_addr", log_q[i], 32'h1000 + 32'(4 * i));
        chk("f0_idle", req, 0);

        log_q.delete(); chk_pix = 1'b1;
        for (int y = 0; y < VLINE; y++) begin
            for (int x = 0; x < HLINE; x++) begin
                de = 1'b1; px = 11'(x); py = 11'(y); tick;
                if (x == 0) begin
                    if (y < VLINE - 1) begin
                        chk("trig_req", req, 1);
                        chk("trig_addr", addr, 32'h1000 + 32'(16 * (y + 1)));
                    end else chk("last_line_no_req", req, 0);
                end
                if (y == 0 && x > 0) chk("tbl_pix", {ode, r, g, b}, {1'b1, tbl[x - 1].rgb});
            end
            de = 1'b0; tick;
            if (y == 0) chk("tbl_pix", {ode, r, g, b}, {1'b1, tbl[7].rgb});
            repeat (5) tick;
        end
        chk_pix = 1'b0;
        chk("frame_count", log_q.size(), 12);
        chk("frame_last", log_q[$], 32'h103C);
        chk("no_underrun", und, 0);

        ready = 1'b0; base = 32'h2000; tick;
        de = 1'b1; px = 0; py = 0; tick; de = 1'b0;
        chk("base_held_addr", addr, 32'h1040);
        chk("base_held_req", req, 1);
        vs = 1'b0; tick; vs = 1'b1; tick;
        chk("fs_wait_addr", addr, 32'h1040);
        chk("fs_underrun", und, 1);
        log_q.delete(); ready = 1'b1; repeat (8) tick;
        chk("fs_count", log_q.size(), 5);
        chk("fs_first", log_q[0], 32'h1040);
        for (int i = 0; i < 4; i++) chk("fs_reload", log_q[i + 1], 32'h2000 + 32'(4 * i));
        chk("fs_idle", req, 0);

        ready = 1'b0; de = 1'b1; px = 0; py = 0; tick; de = 1'b0; tick;
        chk("pre_rst_req", req, 1);
        chk("pre_rst_addr", addr, 32'h2010);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_req", req, 0);
        chk("rst_async_addr", addr, 0);
        tick; tick; rst = 1'b0;
        ready = 1'b1; log_q.delete();
        de = 1'b1; px = 0; py = 0; tick; de = 1'b0; repeat (6) tick;
        chk("post_rst_quiet", log_q.size(), 0);
        chk("post_rst_req", req, 0);
        chk("post_rst_und", und, 0);

        ready = 1'b0; vs = 1'b0; tick; vs = 1'b1; tick;
        chk("ur_req", req, 1);
        chk("ur_addr", addr, 32'h2000);
        de = 1'b1; px = 0; py = 0; tick; de = 1'b0; tick;
        chk("ur_underrun", und, 1);
        chk("ur_hold", addr, 32'h2000);
        log_q.delete(); ready = 1'b1; repeat (8) tick;
        chk("ur_count", log_q.size(), 4);
        for (int i = 0; i < 4; i++) chk("ur_addr_seq", log_q[i], 32'h2000 + 32'(4 * i));
        chk("ur_idle", req, 0);

        repeat (300) begin
            hs = 1'($urandom); vs = 1'($urandom); de = 1'($urandom);
            px = 11'($urandom_range(0, 7)); py = 11'($urandom_range(0, 3));
            ready = 1'($urandom);
            tick;
        end
        hs = 1'b1; vs = 1'b1; de = 1'b0; repeat (4) tick;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
